mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the core's two memory initiators: instruction fetch and load/store unit.
//  Arbitrates fetch and LSU requests and serves them from a word-addressed backing SRAM.
//  Returns one response per accepted request after a fixed latency.
//  Sits outside the core (testbench/SoC top); the core has no back-pressure on responses.
// PARAMETERS
//  ADDR_WIDTH  32  request address width (byte address)
//  DATA_WIDTH  32  word width; byte enables = DATA_WIDTH/8
//  DEPTH_LOG2  12  log2 of SRAM depth in words
//  LATENCY     2   cycles from request acceptance to response valid; legal range >=1
// PORTS
//  i_clk            in   1           clock
//  i_rst_n          in   1           reset, synchronous, active-low
//  i_if_req_valid   in   1           fetch request valid
//  o_if_req_ready   out  1           fetch request accepted this cycle
//  i_if_req_addr    in   ADDR_WIDTH  fetch byte address
//  o_if_resp_valid  out  1           fetch response valid (1-cycle pulse)
//  o_if_resp_data   out  DATA_WIDTH  fetched word
//  o_if_resp_err    out  1           fetch access fault
//  i_ls_req_valid   in   1           LSU request valid
//  o_ls_req_ready   out  1           LSU request accepted this cycle
//  i_ls_req_addr    in   ADDR_WIDTH  LSU byte address
//  i_ls_req_we      in   1           1=store, 0=load
//  i_ls_req_be      in   DATA_WIDTH/8  store byte enables
//  i_ls_req_wdata   in   DATA_WIDTH  store data (byte lanes aligned to word)
//  o_ls_resp_valid  out  1           LSU response valid (1-cycle pulse; also for stores)
//  o_ls_resp_data   out  DATA_WIDTH  load word (0 for stores)
//  o_ls_resp_err    out  1           LSU access fault
// BEHAVIOUR
//  - Reset: FSM=IDLE, counter=0, last_grant=FETCH; all outputs 0. SRAM contents not reset.
//  - FSM: IDLE -> (accept) -> WAIT, or RESP if LATENCY==1.
//    WAIT counts down LATENCY-1 cycles -> RESP. RESP drives resp_valid 1 cycle -> IDLE.
//  - One outstanding request; both ready outputs are 0 outside IDLE.
//  - Handshake: accept when valid & ready in the same cycle. Ready is combinational on valids.
//    Ready is asserted in IDLE only for the arbitration winner.
//  - Arbitration (IDLE): single requester wins. If both request, the port not granted last wins.
//    Reset last_grant=FETCH, so the LSU wins the first tie.
//  - Latency: request accepted at cycle N -> resp_valid at cycle N+LATENCY on the granted port only.
//    The other port's resp_valid stays 0.
//  - Captured at acceptance: port id, we, error flag, word index = addr[DEPTH_LOG2+1:2].
//  - Read data is sampled from the SRAM in the RESP cycle (registered into resp_data).
//  - Error conditions: addr[1:0]!=0, or any addr bit above DEPTH_LOG2+1 set.
//    On error: no SRAM write, resp_data=0, resp_err=1.
//  - Store: written in the acceptance cycle, per-byte via be; be==0 writes nothing, no error.
//    Response data=0.
//  - Store then load to the same word: the load returns the new data (write precedes read).
//  - Input changes while not ready are ignored; a valid deasserted before acceptance is never served.
//  - Reset mid-operation: in-flight request dropped, no response emitted, and no pending write
//    (writes happen only at acceptance).
//  - Flush is not visible here; the core discards stale fetch responses itself.
// STRUCTURE
//  - Shared package gets: mem_port_e {MEM_PORT_FETCH, MEM_PORT_LSU}, mem_resp_state_e {IDLE, WAIT, RESP},
//    and mem_req_t (addr, we, be, wdata) for reuse by fetch/lsu request drivers.
//  - One sub-module, mem_sram_be: DEPTH x DATA_WIDTH array, one port, synchronous byte-enable write,
//    combinational read. FSM, arbiter and latency counter stay in mem_responder.
// TESTING  (LATENCY=2 unless noted)
//  - Fetch only: SRAM[4]=0x00100093; fetch addr 0x10 accepted at cycle N ->
//    if_resp_valid=1, data=0x00100093, err=0 at N+2; ls_resp_valid stays 0.
//  - Store/load: store addr 0x20, be=4'b0011, wdata=0xAABBCCDD over 0x11223344 -> ls resp at N+2, data=0;
//    next load 0x20 returns 0x1122CCDD.
//  - Tie: both valid from reset -> LSU granted first. Fetch granted on the next IDLE.
//    Interleaving alternates under continuous requests.
//  - Faults: load 0x22 -> err=1, data=0. Store to 0x00004000 (DEPTH_LOG2=12) -> err=1, SRAM unchanged.
//  - Reset asserted in WAIT -> no resp_valid on either port; first request after reset served normally.
//  - LATENCY=1: back-to-back fetches accepted every 2 cycles; each response exactly 1 cycle after acceptance.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder and for the fetch/LSU request drivers.
// The ports, response states and request record live here.
package mem_responder_pkg;

   localparam int MEM_ADDR_WIDTH = 32;
   localparam int MEM_DATA_WIDTH = 32;

   typedef enum logic {
      MEM_PORT_FETCH = 1'b0,
      MEM_PORT_LSU   = 1'b1
   } mem_port_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_resp_state_e;

   typedef struct packed {
      logic [MEM_ADDR_WIDTH-1:0]   addr;
      logic                        we;
      logic [MEM_DATA_WIDTH/8-1:0] be;
      logic [MEM_DATA_WIDTH-1:0]   wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_sram_be.sv
// Single-port word SRAM with synchronous per-byte write and combinational read.
module mem_sram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DEPTH_LOG2-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

   // NOTE: the array has no reset; clearing every word would turn it into flops.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Arbitrates fetch and LSU requests onto one backing SRAM and returns a single
// response per accepted request after LATENCY cycles.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_if_req_valid,
   output logic                    o_if_req_ready,
   input  logic [ADDR_WIDTH-1:0]   i_if_req_addr,
   output logic                    o_if_resp_valid,
   output logic [DATA_WIDTH-1:0]   o_if_resp_data,
   output logic                    o_if_resp_err,
   input  logic                    i_ls_req_valid,
   output logic                    o_ls_req_ready,
   input  logic [ADDR_WIDTH-1:0]   i_ls_req_addr,
   input  logic                    i_ls_req_we,
   input  logic [DATA_WIDTH/8-1:0] i_ls_req_be,
   input  logic [DATA_WIDTH-1:0]   i_ls_req_wdata,
   output logic                    o_ls_resp_valid,
   output logic [DATA_WIDTH-1:0]   o_ls_resp_data,
   output logic                    o_ls_resp_err
);

   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   mem_resp_state_e       state;
   logic [CNT_W-1:0]      count;
   mem_port_e             last_grant;
   mem_port_e             cap_port;
   logic                  cap_we;
   logic                  cap_err;
   logic [DEPTH_LOG2-1:0] cap_idx;

   logic                  ls_wins;
   logic                  accept;
   mem_port_e             req_port;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_we;
   logic                  req_err;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [DEPTH_LOG2-1:0] sram_idx;
   logic                  sram_we;
   logic [DATA_WIDTH-1:0] sram_rdata;
   mem_port_e             resp_port;
   logic                  resp_err;
   logic [DATA_WIDTH-1:0] resp_word;
   logic                  emit;

   // NOTE: every combinational output gets a value on every path, so no latches.
   always_comb begin
      ls_wins        = i_ls_req_valid && (!i_if_req_valid || last_grant == MEM_PORT_FETCH);
      o_ls_req_ready = i_rst_n && (state == IDLE) && ls_wins;
      o_if_req_ready = i_rst_n && (state == IDLE) && i_if_req_valid && !ls_wins;
      accept         = o_ls_req_ready || o_if_req_ready;
      req_port       = ls_wins ? MEM_PORT_LSU : MEM_PORT_FETCH;
      req_addr       = ls_wins ? i_ls_req_addr : i_if_req_addr;
      req_we         = ls_wins && i_ls_req_we;
      req_err        = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != '0);
      req_idx        = req_addr[DEPTH_LOG2+1:2];
      // Stores land in the acceptance cycle, so a later load always sees them.
      sram_we        = o_ls_req_ready && i_ls_req_we && !req_err;
      sram_idx       = (state == IDLE) ? req_idx : cap_idx;

      // With LATENCY==1 the response is launched from IDLE using the live request.
      resp_port = (state == IDLE) ? req_port : cap_port;
      resp_err  = (state == IDLE) ? req_err : cap_err;
      resp_word = (resp_err || ((state == IDLE) ? req_we : cap_we)) ? '0 : sram_rdata;
      emit      = ((state == IDLE) && accept && (LATENCY == 1)) ||
                  ((state == WAIT) && (count == '0));
   end

   mem_sram_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_sram (
      .clk   (i_clk),
      .we    (sram_we),
      .be    (i_ls_req_be),
      .addr  (sram_idx),
      .wdata (i_ls_req_wdata),
      .rdata (sram_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         count           <= '0;
         last_grant      <= MEM_PORT_FETCH;
         cap_port        <= MEM_PORT_FETCH;
         cap_we          <= 1'b0;
         cap_err         <= 1'b0;
         cap_idx         <= '0;
         o_if_resp_valid <= 1'b0;
         o_if_resp_data  <= '0;
         o_if_resp_err   <= 1'b0;
         o_ls_resp_valid <= 1'b0;
         o_ls_resp_data  <= '0;
         o_ls_resp_err   <= 1'b0;
      end else begin
         o_if_resp_valid <= 1'b0;
         o_if_resp_data  <= '0;
         o_if_resp_err   <= 1'b0;
         o_ls_resp_valid <= 1'b0;
         o_ls_resp_data  <= '0;
         o_ls_resp_err   <= 1'b0;

         if (emit) begin
            if (resp_port == MEM_PORT_FETCH) begin
               o_if_resp_valid <= 1'b1;
               o_if_resp_data  <= resp_word;
               o_if_resp_err   <= resp_err;
            end else begin
               o_ls_resp_valid <= 1'b1;
               o_ls_resp_data  <= resp_word;
               o_ls_resp_err   <= resp_err;
            end
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  cap_port   <= req_port;
                  cap_we     <= req_we;
                  cap_err    <= req_err;
                  cap_idx    <= req_idx;
                  last_grant <= req_port;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     count <= CNT_W'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (count == '0) state <= RESP;
               else             count <= count - 1'b1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
